// File: rtl/qdma_h2c_pkt_player.sv
// AXI-Stream packet player: beats are preloaded into a beat RAM in IDLE, then
// replayed a programmable number of passes with an inter-packet gap and tready back-pressure.
module qdma_h2c_pkt_player #(
    parameter int DATA_W = 512,
    parameter int MTY_W  = 6,
    parameter int DEPTH  = 64,
    parameter int GAP_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [MTY_W-1:0]  ld_mty,
    input  logic              ld_last,
    input  logic [31:0]       ld_crc,
    input  logic              start,
    input  logic              abort,
    input  logic [GAP_W-1:0]  gap_cfg,
    input  logic [CNT_W-1:0]  loop_cfg,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [MTY_W-1:0]  m_axis_tuser_mty,
    output logic [31:0]       m_axis_tcrc,
    output logic              busy,
    output logic              done,
    output logic              err_start,
    output logic [CNT_W-1:0]  pkt_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

    state_t state;

    logic [DATA_W-1:0] ram_data [DEPTH];
    logic [MTY_W-1:0]  ram_mty  [DEPTH];
    logic              ram_last [DEPTH];
    logic [31:0]       ram_crc  [DEPTH];

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_nx;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic              last_flag;

    logic [DATA_W-1:0] nxt_data;
    logic [MTY_W-1:0]  nxt_mty;
    logic              nxt_last;
    logic [31:0]       nxt_crc;
    logic [31:0]       cur_crc;

    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic [CNT_W-1:0]  loop_q;
    logic [CNT_W-1:0]  pass;
    logic              abort_l;
    logic              final_q;

    logic              do_load;
    logic [PW-1:0]     wr_post;
    logic              last_post;
    logic              start_ok;
    logic              accept;
    logic              end_of_ram;
    logic              pkt_final;
    logic              gap_end;
    logic              gap_stop;
    logic              load_out;

    assign ld_ready   = (state == IDLE) && (wr_ptr < PW'(DEPTH));
    assign busy       = (state != IDLE);
    assign do_load    = ld_valid && ld_ready && !clear;
    assign wr_post    = do_load ? wr_ptr + PW'(1) : wr_ptr;
    assign last_post  = do_load ? ld_last : last_flag;
    assign start_ok   = (state == IDLE) && start && !clear && (wr_post != '0) && last_post;
    assign accept     = (state == PLAY) && m_axis_tvalid && m_axis_tready;
    assign end_of_ram = (rd_ptr == wr_ptr);
    assign pkt_final  = abort_l || abort || (end_of_ram && (pass >= loop_q));
    assign gap_end    = (state == GAP) && (gap_cnt == gap_q);
    assign gap_stop   = final_q || abort_l || abort;
    assign load_out   = (state == FETCH) || (accept && !m_axis_tlast) || (gap_end && !gap_stop);
    assign wr_addr    = wr_ptr[AW-1:0];
    assign rd_addr    = rd_ptr_nx[AW-1:0];

    // rd_ptr always names the beat after the one on the bus; the wrap for the next
    // pass is taken at the last beat so the prefetch completes during the gap.
    always_comb begin
        rd_ptr_nx = rd_ptr;
        case (state)
            IDLE:  rd_ptr_nx = '0;
            FETCH: rd_ptr_nx = rd_ptr + PW'(1);
            PLAY: begin
                if (accept) begin
                    if (!m_axis_tlast)
                        rd_ptr_nx = rd_ptr + PW'(1);
                    else if (end_of_ram && !pkt_final)
                        rd_ptr_nx = '0;
                end
            end
            GAP: begin
                if (gap_end && !gap_stop)
                    rd_ptr_nx = rd_ptr + PW'(1);
            end
            default: rd_ptr_nx = rd_ptr;
        endcase
    end

    // Write-first bypass keeps the prefetch correct when a beat lands at the read address.
    always_ff @(posedge clk) begin
        if (do_load) begin
            ram_data[wr_addr] <= ld_data;
            ram_mty[wr_addr]  <= ld_last ? ld_mty : '0;
            ram_last[wr_addr] <= ld_last;
            ram_crc[wr_addr]  <= ld_crc;
        end
        if (do_load && (wr_addr == rd_addr)) begin
            nxt_data <= ld_data;
            nxt_mty  <= ld_last ? ld_mty : '0;
            nxt_last <= ld_last;
            nxt_crc  <= ld_crc;
        end else begin
            nxt_data <= ram_data[rd_addr];
            nxt_mty  <= ram_mty[rd_addr];
            nxt_last <= ram_last[rd_addr];
            nxt_crc  <= ram_crc[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            last_flag        <= 1'b0;
            gap_q            <= '0;
            gap_cnt          <= '0;
            loop_q           <= '0;
            pass             <= '0;
            abort_l          <= 1'b0;
            final_q          <= 1'b0;
            cur_crc          <= '0;
            m_axis_tdata     <= '0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tlast     <= 1'b0;
            m_axis_tuser_mty <= '0;
            m_axis_tcrc      <= '0;
            done             <= 1'b0;
            err_start        <= 1'b0;
            pkt_cnt          <= '0;
        end else begin
            done      <= 1'b0;
            err_start <= 1'b0;
            rd_ptr    <= rd_ptr_nx;
            if ((state != IDLE) && abort)
                abort_l <= 1'b1;

            case (state)
                IDLE: begin
                    if (clear) begin
                        wr_ptr    <= '0;
                        last_flag <= 1'b0;
                    end else begin
                        if (do_load) begin
                            wr_ptr    <= wr_ptr + PW'(1);
                            last_flag <= ld_last;
                        end
                        if (start_ok) begin
                            pkt_cnt <= '0;
                            pass    <= CNT_W'(1);
                            loop_q  <= (loop_cfg == '0) ? CNT_W'(1) : loop_cfg;
                            gap_q   <= gap_cfg;
                            abort_l <= 1'b0;
                            final_q <= 1'b0;
                            state   <= FETCH;
                        end else if (start) begin
                            err_start <= 1'b1;
                        end
                    end
                end
                FETCH: state <= PLAY;
                PLAY: begin
                    if (accept && m_axis_tlast) begin
                        m_axis_tvalid    <= 1'b0;
                        m_axis_tlast     <= 1'b0;
                        m_axis_tuser_mty <= '0;
                        m_axis_tcrc      <= cur_crc;
                        pkt_cnt          <= pkt_cnt + CNT_W'(1);
                        gap_cnt          <= '0;
                        final_q          <= pkt_final;
                        if (end_of_ram && !pkt_final)
                            pass <= pass + CNT_W'(1);
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        if (gap_stop) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= PLAY;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (load_out) begin
                m_axis_tdata     <= nxt_data;
                m_axis_tlast     <= nxt_last;
                m_axis_tuser_mty <= nxt_mty;
                cur_crc          <= nxt_crc;
                m_axis_tvalid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qdma_h2c_pkt_player.sv
// Scoreboard bench for qdma_h2c_pkt_player: a model beat RAM feeds an expected-beat queue
// that a negedge monitor pops against accepted output beats, with timing and hold checks.
module tb_qdma_h2c_pkt_player;

    localparam int DATA_W = 512;
    localparam int MTY_W  = 6;
    localparam int DEPTH  = 16;
    localparam int GAP_W  = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data = '0;
    logic [MTY_W-1:0]  ld_mty = '0;
    logic              ld_last = 1'b0;
    logic [31:0]       ld_crc = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [GAP_W-1:0]  gap_cfg = '0;
    logic [CNT_W-1:0]  loop_cfg = '0;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tlast;
    logic [MTY_W-1:0]  m_axis_tuser_mty;
    logic [31:0]       m_axis_tcrc;
    logic              busy;
    logic              done;
    logic              err_start;
    logic [CNT_W-1:0]  pkt_cnt;

    qdma_h2c_pkt_player #(
        .DATA_W(DATA_W), .MTY_W(MTY_W), .DEPTH(DEPTH), .GAP_W(GAP_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_mty(ld_mty),
        .ld_last(ld_last), .ld_crc(ld_crc),
        .start(start), .abort(abort), .gap_cfg(gap_cfg), .loop_cfg(loop_cfg),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser_mty(m_axis_tuser_mty), .m_axis_tcrc(m_axis_tcrc),
        .busy(busy), .done(done), .err_start(err_start), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
        logic [MTY_W-1:0]  m;
        logic [31:0]       c;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] m_data [32];
    logic              m_last [32];
    logic [MTY_W-1:0]  m_mty  [32];
    logic [31:0]       m_crc  [32];
    int                m_n = 0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_cyc = 0;
    int exp_gap = 0;
    int exp_pkts = 0;
    int acc_beats = 0;
    int done_cnt = 0;
    int done_base = 0;
    int err_cnt = 0;
    int tv_cnt = 0;
    int stall_at = 0;
    int stall_rem = 0;
    bit have_last = 0;
    bit in_pkt = 0;
    bit crc_pending = 0;
    logic [31:0] pend_crc;
    bit hold_v = 0;
    logic [DATA_W-1:0] hold_d;
    logic hold_l;
    logic [MTY_W-1:0] hold_m;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Back-pressure: hold tready low for stall_rem cycles while beat stall_at is offered.
    always @(posedge clk) begin
        #1;
        if (stall_rem > 0 && acc_beats == stall_at && m_axis_tvalid) begin
            m_axis_tready = 1'b0;
            stall_rem--;
        end else begin
            m_axis_tready = 1'b1;
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            in_pkt = 0;
            crc_pending = 0;
            hold_v = 0;
        end else begin
            if (crc_pending) begin
                checkOutput("tcrc", m_axis_tcrc, pend_crc);
                checkOutput("pkt_cnt", pkt_cnt, exp_pkts);
                crc_pending = 0;
            end
            if (hold_v) begin
                checkOutput("hold_valid", m_axis_tvalid, 1);
                checkOutput("hold_data", m_axis_tdata, hold_d);
                checkOutput("hold_last", m_axis_tlast, hold_l);
                checkOutput("hold_mty", m_axis_tuser_mty, hold_m);
            end
            hold_v = m_axis_tvalid && !m_axis_tready;
            hold_d = m_axis_tdata;
            hold_l = m_axis_tlast;
            hold_m = m_axis_tuser_mty;
            if (m_axis_tvalid) tv_cnt++;
            if (in_pkt) checkOutput("tvalid_mid", m_axis_tvalid, 1);
            if (m_axis_tvalid && !in_pkt) begin
                if (have_last) checkOutput("gap_idle", cyc - last_cyc - 1, exp_gap + 1);
                else checkOutput("start_lat", cyc - start_cyc, 2);
                in_pkt = 1;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                acc_beats++;
                if (exp_q.size() == 0) begin
                    checkOutput("q_underflow", exp_q.size(), 1);
                end else begin
                    b = exp_q.pop_front();
                    checkOutput("beat_data", m_axis_tdata, b.d);
                    checkOutput("beat_last", m_axis_tlast, b.l);
                    checkOutput("beat_mty", m_axis_tuser_mty, b.m);
                    if (b.l) begin
                        exp_pkts++;
                        crc_pending = 1;
                        pend_crc = b.c;
                    end
                end
                if (m_axis_tlast) begin
                    in_pkt = 0;
                    last_cyc = cyc;
                    have_last = 1;
                end
            end
            if (done) begin
                done_cnt++;
                if (have_last) checkOutput("done_lat", cyc - last_cyc, exp_gap + 2);
            end
            if (err_start) err_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_beat();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic applyStimulus(input int nb, input logic [MTY_W-1:0] mty, input logic [31:0] crc);
        for (int b = 0; b < nb; b++) begin
            ld_data  = rnd_beat();
            ld_last  = (b == nb - 1);
            ld_mty   = mty;
            ld_crc   = ld_last ? crc : $urandom();
            ld_valid = 1'b1;
            m_data[m_n] = ld_data;
            m_last[m_n] = ld_last;
            m_mty[m_n]  = ld_last ? mty : '0;
            m_crc[m_n]  = crc;
            m_n++;
            tick(1);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        m_n = 0;
    endtask

    task automatic start_replay(input int gap, input int loops, input int limit);
        int passes;
        int pushed;
        beat_t b;
        passes = (loops == 0) ? 1 : loops;
        pushed = 0;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < m_n; i++)
                if (limit < 0 || pushed < limit) begin
                    b.d = m_data[i]; b.l = m_last[i]; b.m = m_mty[i]; b.c = m_crc[i];
                    exp_q.push_back(b);
                    pushed++;
                end
        exp_gap   = gap;
        exp_pkts  = 0;
        acc_beats = 0;
        have_last = 0;
        done_base = done_cnt;
        start_cyc = cyc;
        gap_cfg   = GAP_W'(gap);
        loop_cfg  = CNT_W'(loops);
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            tick(1);
            n++;
        end
        if (done_cnt == done_base) checkOutput(tag, done_cnt - done_base, 1);
        tick(2);
        checkOutput("q_empty", exp_q.size(), 0);
        checkOutput("done_once", done_cnt - done_base, 1);
        checkOutput("busy_end", busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_tvalid"}, m_axis_tvalid, 0);
        checkOutput({tag, "_tlast"}, m_axis_tlast, 0);
        checkOutput({tag, "_tdata"}, m_axis_tdata, 0);
        checkOutput({tag, "_mty"}, m_axis_tuser_mty, 0);
        checkOutput({tag, "_tcrc"}, m_axis_tcrc, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err_start, 0);
        checkOutput({tag, "_pkt_cnt"}, pkt_cnt, 0);
        checkOutput({tag, "_ld_ready"}, ld_ready, 1);
    endtask

    initial begin
        int eb;
        int tb0;
        int n;
        tick(3);
        check_idle_outputs("reset");
        reset = 1'b0;
        tick(1);

        $display("[TB] 2-beat packet, gap 30");
        applyStimulus(2, 6'd44, 32'hE1B2972D);
        start_replay(30, 1, -1);
        wait_done(200, "t1_timeout");
        checkOutput("t1_tcrc_held", m_axis_tcrc, 32'hE1B2972D);

        $display("[TB] three packets, gap 0");
        do_clear();
        applyStimulus(2, 6'd3, 32'h11112222);
        applyStimulus(3, 6'd17, 32'h33334444);
        applyStimulus(2, 6'd63, 32'h55556666);
        start_replay(0, 1, -1);
        wait_done(200, "t2_timeout");
        checkOutput("t2_pkt_cnt", pkt_cnt, 3);

        $display("[TB] back-pressure on beat 2");
        do_clear();
        applyStimulus(3, 6'd9, 32'hCAFEF00D);
        stall_at  = 1;
        stall_rem = 5;
        start_replay(3, 1, -1);
        wait_done(200, "t3_timeout");
        checkOutput("t3_stall_used", stall_rem, 0);

        $display("[TB] loop 3 and loop 0");
        do_clear();
        applyStimulus(2, 6'd5, 32'h0BADBEEF);
        start_replay(2, 3, -1);
        wait_done(200, "t4_timeout");
        checkOutput("t4_pkt_cnt", pkt_cnt, 3);
        start_replay(1, 0, -1);
        wait_done(200, "t4b_timeout");
        checkOutput("t4b_pkt_cnt", pkt_cnt, 1);

        $display("[TB] rejected starts");
        do_clear();
        eb = err_cnt; tb0 = tv_cnt;
        pulse_start();
        checkOutput("err_empty", err_cnt - eb, 1);
        checkOutput("err_empty_busy", busy, 0);
        ld_data = rnd_beat(); ld_last = 1'b0; ld_valid = 1'b1;
        tick(1);
        ld_valid = 1'b0;
        pulse_start();
        checkOutput("err_nolast", err_cnt - eb, 2);
        checkOutput("err_nolast_busy", busy, 0);
        checkOutput("err_no_tvalid", tv_cnt - tb0, 0);
        do_clear();
        applyStimulus(1, 6'd1, 32'h12345678);
        clear = 1'b1; start = 1'b1;
        tick(1);
        clear = 1'b0; start = 1'b0; m_n = 0;
        tick(2);
        checkOutput("clear_start_err", err_cnt - eb, 2);
        checkOutput("clear_start_busy", busy, 0);
        pulse_start();
        checkOutput("cleared_err", err_cnt - eb, 3);
        checkOutput("cleared_no_tvalid", tv_cnt - tb0, 0);

        $display("[TB] load and start together");
        ld_data = rnd_beat(); ld_last = 1'b1; ld_mty = 6'd21; ld_crc = 32'hA5A5A5A5;
        ld_valid = 1'b1;
        m_data[0] = ld_data; m_last[0] = 1'b1; m_mty[0] = 6'd21; m_crc[0] = 32'hA5A5A5A5;
        m_n = 1;
        start_replay(0, 1, -1);
        ld_valid = 1'b0; ld_last = 1'b0;
        wait_done(100, "t5_timeout");

        $display("[TB] full beat RAM");
        do_clear();
        for (int p = 0; p < DEPTH / 4; p++) applyStimulus(4, 6'(p + 2), 32'h9000 + p);
        checkOutput("full_ld_ready", ld_ready, 0);
        ld_data = rnd_beat(); ld_last = 1'b1; ld_valid = 1'b1;
        tick(1);
        ld_valid = 1'b0; ld_last = 1'b0;
        start_replay(1, 1, -1);
        wait_done(300, "full_timeout");
        checkOutput("full_pkt_cnt", pkt_cnt, DEPTH / 4);

        $display("[TB] abort in first packet");
        do_clear();
        for (int p = 0; p < 3; p++) applyStimulus(3, 6'd7, 32'h7000 + p);
        start_replay(2, 1, 3);
        n = 0;
        while (acc_beats < 1 && n < 50) begin tick(1); n++; end
        checkOutput("abort_wait", acc_beats, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_done(100, "abort_timeout");
        checkOutput("abort_pkt_cnt", pkt_cnt, 1);

        $display("[TB] reset during replay");
        start_replay(0, 5, -1);
        n = 0;
        while (acc_beats < 4 && n < 100) begin tick(1); n++; end
        checkOutput("rst_wait", acc_beats >= 4, 1);
        reset = 1'b1;
        tick(1);
        check_idle_outputs("midrst");
        reset = 1'b0;
        exp_q.delete();
        m_n = 0;
        tick(2);
        checkOutput("post_rst_busy", busy, 0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
